// File: rtl/chi_package.sv
// CHI request-flit layout, opcode constants and link state type.
// Field offsets are the single source for every REQ-flit decoder.
package chi_package;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int SRCID_LSB  = 7;
  localparam int SRCID_W    = 7;
  localparam int TXNID_LSB  = 14;
  localparam int TXNID_W    = 8;
  localparam int ADDR_LSB   = 22;

  localparam logic [6:0] REQ_READ_SHARED     = 7'h01;
  localparam logic [6:0] REQ_READ_CLEAN      = 7'h02;
  localparam logic [6:0] REQ_READ_UNIQUE     = 7'h07;
  localparam logic [6:0] REQ_WRITE_BACK_FULL = 7'h1B;

  localparam logic [6:0] NODE_RN1 = 7'b000_0001;
  localparam logic [6:0] NODE_RN2 = 7'b000_0010;
  localparam logic [6:0] NODE_RN3 = 7'b000_0100;
  localparam logic [6:0] NODE_RN4 = 7'b000_1000;

  typedef struct packed {
    logic [41:0] addr;
    logic [7:0]  txnid;
    logic [6:0]  srcid;
    logic [6:0]  opcode;
  } req_flit_t;

  typedef enum logic [1:0] {
    LNK_INIT   = 2'd0,
    LNK_CREDIT = 2'd1,
    LNK_RUN    = 2'd2
  } link_state_e;

endpackage

// File: rtl/llc_config_pkg.sv
// LLC / Home Node build-time configuration defaults.
// Shared by the HN request-path blocks.
package llc_config_pkg;

  localparam int RXREQ_DEPTH = 4;

endpackage

// File: rtl/hn_sync_fifo.sv
// Generic DEPTH x W register FIFO; head is read from registers.
// Push while full is accepted only together with a pop.
module hn_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd;
  logic          wr;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hn_rxreq_link.sv
// CHI RX REQ link receiver: L-credit flow control into a FIFO.
// Optional protocol checker: HN_RXREQ_PROTO_CHECK_EN.
module hn_rxreq_link
  import chi_package::*;
#(
  parameter int DEPTH  = llc_config_pkg::RXREQ_DEPTH,
  parameter int FLIT_W = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_flitpend,
  input  logic                 rx_flitv,
  input  logic [FLIT_W-1:0]    rx_flit,
  output logic                 rx_lcrdv,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [6:0]           req_opcode,
  output logic [6:0]           req_srcid,
  output logic [7:0]           req_txnid,
  output logic [FLIT_W-23:0]   req_addr,
  output logic                 link_up,
  output logic [CNT_W-1:0]     fifo_count
`ifdef HN_RXREQ_PROTO_CHECK_EN
  ,
  output logic                 proto_err,
  output logic [7:0]           err_cnt
`endif
);

  link_state_e       state;
  link_state_e       state_nxt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [CNT_W-1:0]  ret_nxt;
  logic [CNT_W-1:0]  gnt_cnt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [FLIT_W-1:0] head;
  logic [FLIT_W-1:0] hd;
  logic              flitpend_d1;
  logic              unused_pend;

  assign push      = rx_flitv && (gnt_cnt != '0);
  assign req_valid = !empty;
  assign pop       = req_valid && req_ready;

  hn_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (FLIT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (rx_flit),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LNK_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    ret_nxt = ret_cnt;
    if (state == LNK_INIT)
      ret_nxt = CNT_W'(DEPTH);
    else if (pop && !rx_lcrdv && ret_cnt != CNT_W'(DEPTH))
      ret_nxt = ret_cnt + CNT_W'(1);
    else if (!pop && rx_lcrdv)
      ret_nxt = ret_cnt - CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LNK_INIT:   state_nxt = LNK_CREDIT;
      LNK_CREDIT: if (ret_nxt == '0) state_nxt = LNK_RUN;
      LNK_RUN:    state_nxt = LNK_RUN;
      default:    state_nxt = LNK_INIT;
    endcase
  end

  always_comb begin
    rx_lcrdv = (state != LNK_INIT) && (ret_cnt != '0);
    link_up  = (state == LNK_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ret_cnt     <= '0;
      gnt_cnt     <= '0;
      flitpend_d1 <= 1'b0;
    end else begin
      ret_cnt     <= ret_nxt;
      gnt_cnt     <= gnt_cnt + CNT_W'(rx_lcrdv) - CNT_W'(push);
      flitpend_d1 <= rx_flitpend;
    end
  end

  assign unused_pend = flitpend_d1 ^ full;

  // Data fields read as zero whenever there is no head entry.
  assign hd         = head & {FLIT_W{req_valid}};
  assign req_opcode = hd[OPCODE_LSB +: OPCODE_W];
  assign req_srcid  = hd[SRCID_LSB +: SRCID_W];
  assign req_txnid  = hd[TXNID_LSB +: TXNID_W];
  assign req_addr   = hd[FLIT_W-1:ADDR_LSB];

`ifdef HN_RXREQ_PROTO_CHECK_EN
  logic viol;
  assign viol = rx_flitv && (gnt_cnt == '0 || !link_up);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err <= 1'b0;
      err_cnt   <= '0;
    end else if (viol) begin
      proto_err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hn_rxreq_link.sv
// Bench for hn_rxreq_link: directed steps plus random traffic
// against a queue/credit-count reference model.
module tb_hn_rxreq_link;
  import chi_package::*;

  localparam int DEPTH  = 4;
  localparam int FLIT_W = 64;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rx_flitpend = 1'b0;
  logic              rx_flitv = 1'b0;
  logic [FLIT_W-1:0] rx_flit = '0;
  logic              rx_lcrdv;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [6:0]        req_opcode;
  logic [6:0]        req_srcid;
  logic [7:0]        req_txnid;
  logic [41:0]       req_addr;
  logic              link_up;
  logic [CNT_W-1:0]  fifo_count;
`ifdef HN_RXREQ_PROTO_CHECK_EN
  logic              proto_err;
  logic [7:0]        err_cnt;
`endif

  always #5 clk = ~clk;

  hn_rxreq_link #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_flitpend (rx_flitpend),
    .rx_flitv    (rx_flitv),
    .rx_flit     (rx_flit),
    .rx_lcrdv    (rx_lcrdv),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_srcid   (req_srcid),
    .req_txnid   (req_txnid),
    .req_addr    (req_addr),
    .link_up     (link_up),
    .fifo_count  (fifo_count)
`ifdef HN_RXREQ_PROTO_CHECK_EN
    ,
    .proto_err   (proto_err),
    .err_cnt     (err_cnt)
`endif
  );

  int npass = 0;
  int ntot  = 0;

  // Reference model: buffered flits, credits the link still owes,
  // credits held by the transmitter, cycles since reset release.
  logic [63:0] q[$];
  int  m_ret;
  int  m_gnt;
  int  m_t;
  bit  m_link;
  bit  m_err;
  int  m_errcnt;
  int  pulses;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rnd_flit();
    logic [63:0] f;
    f = {$urandom, $urandom};
    return f;
  endfunction

  task automatic cyc(input bit v, input logic [63:0] f, input bit rdy);
    bit          exp_lcrdv;
    bit          push;
    bit          pop;
    bit          viol;
    logic [63:0] h;
    rx_flitv    = v;
    rx_flit     = f;
    req_ready   = rdy;
    rx_flitpend = v;
    exp_lcrdv = (m_t > 0) && (m_ret > 0);
    h = (q.size() != 0) ? q[0] : 64'd0;
    chk("lcrdv", rx_lcrdv, exp_lcrdv);
    chk("req_valid", req_valid, q.size() != 0);
    chk("fifo_count", fifo_count, q.size());
    chk("link_up", link_up, m_link);
    chk("opcode", req_opcode, h[6:0]);
    chk("srcid", req_srcid, h[13:7]);
    chk("txnid", req_txnid, h[21:14]);
    chk("addr", req_addr, h[63:22]);
    if (m_t > 0)
      chk("credit_sum", m_gnt + int'(fifo_count) + m_ret, DEPTH);
`ifdef HN_RXREQ_PROTO_CHECK_EN
    chk("proto_err", proto_err, m_err);
    chk("err_cnt", err_cnt, m_errcnt);
`endif
    viol = v && (m_gnt == 0 || !m_link);
    push = v && (m_gnt > 0);
    pop  = rdy && (q.size() != 0);
    if (exp_lcrdv) pulses++;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(f);
    m_gnt += int'(exp_lcrdv) - int'(push);
    if (m_t == 0) m_ret = DEPTH;
    else m_ret += int'(pop) - int'(exp_lcrdv);
    if (m_t > 0 && m_ret == 0) m_link = 1'b1;
    if (viol) begin
      m_err = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk);
    #1;
    m_t++;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    rx_flitv    = 1'b0;
    rx_flit     = '0;
    req_ready   = 1'b0;
    rx_flitpend = 1'b0;
    #3;
    chk("rst_lcrdv", rx_lcrdv, 1'b0);
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_link_up", link_up, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_opcode", req_opcode, 0);
    chk("rst_txnid", req_txnid, 0);
`ifdef HN_RXREQ_PROTO_CHECK_EN
    chk("rst_proto_err", proto_err, 1'b0);
`endif
    q.delete();
    m_ret = 0; m_gnt = 0; m_t = 0;
    m_link = 1'b0; m_err = 1'b0; m_errcnt = 0; pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] f;
    int p0;

    do_reset();
    repeat (8) cyc(1'b0, 64'd0, 1'b0);
    chk("boot_pulses", pulses, 4);
    chk("boot_link_up", link_up, 1'b1);

    f = {42'h12345, 8'h5A, NODE_RN1, REQ_READ_SHARED};
    cyc(1'b1, f, 1'b0);
    chk("single_valid", req_valid, 1'b1);
    chk("single_op", req_opcode, 7'h01);
    chk("single_txn", req_txnid, 8'h5A);
    cyc(1'b0, 64'd0, 1'b0);
    cyc(1'b0, 64'd0, 1'b0);
    p0 = pulses;
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b0);
    chk("single_ret", pulses - p0, 1);
    repeat (2) cyc(1'b0, 64'd0, 1'b0);

    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_flit(), 1'b0);
    cyc(1'b0, 64'd0, 1'b0);
    chk("fill_count", fifo_count, 4);
    p0 = pulses;
    cyc(1'b1, rnd_flit(), 1'b0);
    chk("drop_count", fifo_count, 4);
    chk("drop_no_lcrdv", pulses - p0, 0);
`ifdef HN_RXREQ_PROTO_CHECK_EN
    chk("drop_proto_err", proto_err, 1'b1);
    chk("drop_err_cnt", err_cnt, 1);
`endif
    p0 = pulses;
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b0);
    chk("drain_pulses", pulses - p0, 4);
    repeat (2) cyc(1'b0, 64'd0, 1'b0);

    cyc(1'b1, rnd_flit(), 1'b0);
    cyc(1'b1, rnd_flit(), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(m_gnt > 0, rnd_flit(), 1'b1);
      chk("pp_count", fifo_count, 2);
    end

    for (int i = 0; i < 300; i++)
      cyc((m_gnt > 0) && ($urandom_range(0, 1) == 1), rnd_flit(),
          $urandom_range(0, 2) != 0);

    repeat (10) cyc(1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_flit(), 1'b0);
    chk("pre_rst_count", fifo_count, 3);
    do_reset();
    repeat (8) cyc(1'b0, 64'd0, 1'b0);
    chk("rerst_pulses", pulses, 4);
    chk("rerst_valid", req_valid, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
